// File: rtl/rob_multiport.sv
// rob_multiport: parametrised reorder buffer with multi-slot allocate,
// multi-port write-back and a thermometer-coded commit group.
// Optional build macro ROB_BR_LIMIT_EN: limits each commit group to one
// branch so a single branch-predictor update port is enough.
//
// Handshakes:
//   allocate transfers when alloc_req_i && alloc_ready_o;
//   write-back port p transfers when wb_valid_i[p] && wb_ready_o[p];
//   the commit group retires when cmt_valid_o[0] && cmt_ready_i, and it is
//   held, and may only grow, while cmt_ready_i is low.
module rob_multiport #(
  parameter int DEPTH        = 64,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 4,
  parameter int WB_PORTS     = 5,
  parameter int PAYLOAD_W    = 64,
  parameter int WB_DATA_W    = 32,
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic                              alloc_req_i,
  input  logic [ALLOC_WIDTH-1:0]            alloc_valid_i,
  input  logic [ALLOC_WIDTH*PAYLOAD_W-1:0]  alloc_payload_i,
  input  logic [ALLOC_WIDTH-1:0]            alloc_excp_i,
  input  logic [ALLOC_WIDTH-1:0]            alloc_is_br_i,
  input  logic [ALLOC_WIDTH-1:0]            alloc_serial_i,
  output logic                              alloc_ready_o,
  output logic [ALLOC_WIDTH*(IDX_W+1)-1:0]  alloc_ptr_o,
  input  logic [WB_PORTS-1:0]               wb_valid_i,
  input  logic [WB_PORTS*IDX_W-1:0]         wb_idx_i,
  input  logic [WB_PORTS-1:0]               wb_head_only_i,
  input  logic [WB_PORTS-1:0]               wb_excp_i,
  input  logic [WB_PORTS-1:0]               wb_redirect_i,
  input  logic [WB_PORTS*WB_DATA_W-1:0]     wb_data_i,
  output logic [WB_PORTS-1:0]               wb_ready_o,
  output logic [COMMIT_WIDTH-1:0]           cmt_valid_o,
  input  logic                              cmt_ready_i,
  output logic [COMMIT_WIDTH*PAYLOAD_W-1:0] cmt_payload_o,
  output logic [COMMIT_WIDTH*WB_DATA_W-1:0] cmt_data_o,
  output logic [COMMIT_WIDTH-1:0]           cmt_excp_o,
  output logic [COMMIT_WIDTH-1:0]           cmt_redirect_o,
  output logic [IDX_W:0]                    count_o,
  output logic                              empty_o,
  output logic                              full_o
);

  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W-1:0]     r_count;
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_complete;
  logic [DEPTH-1:0]     r_excp;
  logic [DEPTH-1:0]     r_redirect;
  logic [DEPTH-1:0]     r_is_br;
  logic [DEPTH-1:0]     r_serial;
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [WB_DATA_W-1:0] r_data    [DEPTH];

  logic                    w_alloc_ready;
  logic                    w_alloc_fire;
  logic                    w_cmt_fire;
  logic [PTR_W-1:0]        w_alloc_cnt;
  logic [PTR_W-1:0]        w_cmt_cnt;
  logic [COMMIT_WIDTH-1:0] w_grp;
  logic [WB_PORTS-1:0]     w_wb_ready;
  logic [WB_PORTS-1:0]     w_wb_fire;

  // Space check uses the registered count only, so a same-cycle commit
  // never feeds back into the allocate handshake.
  assign w_alloc_ready = (r_count <= PTR_W'(DEPTH - ALLOC_WIDTH));
  assign w_alloc_fire  = alloc_req_i & w_alloc_ready;
  assign w_cmt_fire    = w_grp[0] & cmt_ready_i;

  assign alloc_ready_o = w_alloc_ready;
  assign wb_ready_o    = w_wb_ready;
  assign cmt_valid_o   = w_grp;
  assign count_o       = r_count;
  assign empty_o       = (r_count == '0);
  assign full_o        = (r_count == PTR_W'(DEPTH));

  // Allocate pointers per slot and number of entries taken this cycle
  always_comb begin
    alloc_ptr_o = '0;
    w_alloc_cnt = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_ptr_o[i*PTR_W +: PTR_W] = r_tail + PTR_W'(i);
      if (w_alloc_fire && alloc_valid_i[i]) w_alloc_cnt = w_alloc_cnt + PTR_W'(1);
    end
  end

  // Write-back acceptance: head-only ports wait until their entry is head
  always_comb begin
    w_wb_ready = '0;
    w_wb_fire  = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      w_wb_ready[p] = ~wb_head_only_i[p] |
                      ((wb_idx_i[p*IDX_W +: IDX_W] == r_head[IDX_W-1:0]) && (r_count != '0));
      w_wb_fire[p]  = wb_valid_i[p] & w_wb_ready[p];
    end
  end

  // Commit group: contiguous completed entries from head, closed by the first terminator
  always_comb begin
    logic             v_chain;
    logic             v_br_seen;
    logic             v_in;
    logic [IDX_W-1:0] v_idx;
    w_grp          = '0;
    cmt_payload_o  = '0;
    cmt_data_o     = '0;
    cmt_excp_o     = '0;
    cmt_redirect_o = '0;
    v_chain        = 1'b1;
    v_br_seen      = 1'b0;
    v_in           = 1'b0;
    v_idx          = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      v_idx = r_head[IDX_W-1:0] + IDX_W'(i);
      v_in  = v_chain && (PTR_W'(i) < r_count) && r_complete[v_idx];
`ifdef ROB_BR_LIMIT_EN
      if (v_br_seen && r_is_br[v_idx]) v_in = 1'b0;
`endif
      w_grp[i]  = v_in;
      v_chain   = v_in && !(r_excp[v_idx] | r_redirect[v_idx] | r_serial[v_idx]);
      v_br_seen = v_br_seen | (v_in & r_is_br[v_idx]);
      cmt_payload_o[i*PAYLOAD_W +: PAYLOAD_W] = r_payload[v_idx];
      cmt_data_o[i*WB_DATA_W +: WB_DATA_W]    = r_data[v_idx];
      cmt_excp_o[i]     = r_excp[v_idx];
      cmt_redirect_o[i] = r_redirect[v_idx];
    end
  end

  // Number of entries retired this cycle
  always_comb begin
    w_cmt_cnt = '0;
    if (w_cmt_fire) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) w_cmt_cnt = w_cmt_cnt + PTR_W'(w_grp[i]);
    end
  end

  // Pointers, count and per-entry status; flush dominates everything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_complete <= '0;
      r_excp     <= '0;
      r_redirect <= '0;
      r_is_br    <= '0;
      r_serial   <= '0;
    end else if (flush_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_complete <= '0;
    end else begin
      r_tail  <= r_tail + w_alloc_cnt;
      r_head  <= r_head + w_cmt_cnt;
      r_count <= r_count + w_alloc_cnt - w_cmt_cnt;
      if (w_alloc_fire) begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
          if (alloc_valid_i[i]) begin
            r_valid[r_tail[IDX_W-1:0] + IDX_W'(i)]    <= 1'b1;
            r_complete[r_tail[IDX_W-1:0] + IDX_W'(i)] <= alloc_excp_i[i];
            r_excp[r_tail[IDX_W-1:0] + IDX_W'(i)]     <= alloc_excp_i[i];
            r_redirect[r_tail[IDX_W-1:0] + IDX_W'(i)] <= 1'b0;
            r_is_br[r_tail[IDX_W-1:0] + IDX_W'(i)]    <= alloc_is_br_i[i];
            r_serial[r_tail[IDX_W-1:0] + IDX_W'(i)]   <= alloc_serial_i[i];
          end
        end
      end
      // Ascending port order lets the highest port win a collision
      for (int p = 0; p < WB_PORTS; p++) begin
        if (w_wb_fire[p] && r_valid[wb_idx_i[p*IDX_W +: IDX_W]]) begin
          r_complete[wb_idx_i[p*IDX_W +: IDX_W]] <= 1'b1;
          r_excp[wb_idx_i[p*IDX_W +: IDX_W]]     <= wb_excp_i[p];
          r_redirect[wb_idx_i[p*IDX_W +: IDX_W]] <= wb_redirect_i[p];
        end
      end
      if (w_cmt_fire) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
          if (w_grp[i]) begin
            r_valid[r_head[IDX_W-1:0] + IDX_W'(i)]    <= 1'b0;
            r_complete[r_head[IDX_W-1:0] + IDX_W'(i)] <= 1'b0;
          end
        end
      end
    end
  end

  // Payload and result storage; never cleared, validity lives in r_valid
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (w_alloc_fire) begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
          if (alloc_valid_i[i])
            r_payload[r_tail[IDX_W-1:0] + IDX_W'(i)] <= alloc_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (w_wb_fire[p] && r_valid[wb_idx_i[p*IDX_W +: IDX_W]])
          r_data[wb_idx_i[p*IDX_W +: IDX_W]] <= wb_data_i[p*WB_DATA_W +: WB_DATA_W];
      end
    end
  end

  // Two accepted write-backs to one entry in a cycle is a caller error
  always @(posedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        for (int q = p + 1; q < WB_PORTS; q++) begin
          assert (!(w_wb_fire[p] && w_wb_fire[q] &&
                    (wb_idx_i[p*IDX_W +: IDX_W] == wb_idx_i[q*IDX_W +: IDX_W])));
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: directed bench for rob_multiport (default parameters).
module tb_rob_multiport;

  localparam int DEPTH = 64;
  localparam int AW    = 2;
  localparam int CW    = 4;
  localparam int WP    = 5;
  localparam int PW    = 64;
  localparam int DW    = 32;
  localparam int IW    = 6;
  localparam int PTRW  = 7;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic             alloc_req_i;
  logic [AW-1:0]    alloc_valid_i;
  logic [AW*PW-1:0] alloc_payload_i;
  logic [AW-1:0]    alloc_excp_i;
  logic [AW-1:0]    alloc_is_br_i;
  logic [AW-1:0]    alloc_serial_i;
  logic             alloc_ready_o;
  logic [AW*PTRW-1:0] alloc_ptr_o;
  logic [WP-1:0]    wb_valid_i;
  logic [WP*IW-1:0] wb_idx_i;
  logic [WP-1:0]    wb_head_only_i;
  logic [WP-1:0]    wb_excp_i;
  logic [WP-1:0]    wb_redirect_i;
  logic [WP*DW-1:0] wb_data_i;
  logic [WP-1:0]    wb_ready_o;
  logic [CW-1:0]    cmt_valid_o;
  logic             cmt_ready_i;
  logic [CW*PW-1:0] cmt_payload_o;
  logic [CW*DW-1:0] cmt_data_o;
  logic [CW-1:0]    cmt_excp_o;
  logic [CW-1:0]    cmt_redirect_o;
  logic [IW:0]      count_o;
  logic             empty_o;
  logic             full_o;

  rob_multiport dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .alloc_req_i(alloc_req_i), .alloc_valid_i(alloc_valid_i),
    .alloc_payload_i(alloc_payload_i), .alloc_excp_i(alloc_excp_i),
    .alloc_is_br_i(alloc_is_br_i), .alloc_serial_i(alloc_serial_i),
    .alloc_ready_o(alloc_ready_o), .alloc_ptr_o(alloc_ptr_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_head_only_i(wb_head_only_i),
    .wb_excp_i(wb_excp_i), .wb_redirect_i(wb_redirect_i), .wb_data_i(wb_data_i),
    .wb_ready_o(wb_ready_o), .cmt_valid_o(cmt_valid_o), .cmt_ready_i(cmt_ready_i),
    .cmt_payload_o(cmt_payload_o), .cmt_data_o(cmt_data_o), .cmt_excp_o(cmt_excp_o),
    .cmt_redirect_o(cmt_redirect_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: payloads pushed at allocate, popped at commit
  logic [PW-1:0] exp_q[$];
  logic [DW-1:0] m_data [DEPTH];
  bit            m_dvalid [DEPTH];
  int            m_head;
  int            m_tail;
  int            n_checks;
  int            n_errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(negedge clk);
    flush_i = 1'b0; alloc_req_i = 1'b0; alloc_valid_i = '0; alloc_payload_i = '0;
    alloc_excp_i = '0; alloc_is_br_i = '0; alloc_serial_i = '0;
    wb_valid_i = '0; wb_idx_i = '0; wb_head_only_i = '0; wb_excp_i = '0;
    wb_redirect_i = '0; wb_data_i = '0; cmt_ready_i = 1'b0;
  endtask

  task automatic alloc2(input logic [1:0] br, input logic [1:0] ex, input logic [1:0] se,
                        input bit push);
    logic [PW-1:0] pl;
    alloc_req_i = 1'b1; alloc_valid_i = 2'b11;
    alloc_is_br_i = br; alloc_excp_i = ex; alloc_serial_i = se;
    for (int i = 0; i < AW; i++) begin
      pl = {$urandom, $urandom};
      alloc_payload_i[i*PW +: PW] = pl;
      if (push) begin
        exp_q.push_back(pl);
        m_dvalid[(m_tail + i) % DEPTH] = 1'b0;
      end
    end
    if (push) m_tail = m_tail + 2;
  endtask

  task automatic wb(input int p, input int idx, input logic redir, input logic hd, input bit upd);
    logic [DW-1:0] d;
    d = 32'hD000_0000 + 32'(idx * 256 + p) + 32'($urandom_range(0, 15) << 16);
    wb_valid_i[p] = 1'b1;
    wb_idx_i[p*IW +: IW] = IW'(idx);
    wb_redirect_i[p] = redir;
    wb_head_only_i[p] = hd;
    wb_data_i[p*DW +: DW] = d;
    if (upd) begin
      m_data[idx] = d;
      m_dvalid[idx] = 1'b1;
    end
  endtask

  task automatic check_group(input string tag, input logic [CW-1:0] m, input bit commit);
    logic [PW-1:0] pl;
    int idx;
    chk({tag, "_valid"}, 64'(cmt_valid_o), 64'(m));
    if (commit) begin
      cmt_ready_i = 1'b1;
      for (int i = 0; i < CW; i++) begin
        if (m[i]) begin
          idx = (m_head + i) % DEPTH;
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $error("FAIL %s_sb slot %0d observed=commit expected=empty queue", tag, i);
          end else begin
            pl = exp_q.pop_front();
            chk($sformatf("%s_payload%0d", tag, i), cmt_payload_o[i*PW +: PW], pl);
            if (m_dvalid[idx]) chk($sformatf("%s_data%0d", tag, i), 64'(cmt_data_o[i*DW +: DW]), 64'(m_data[idx]));
          end
        end
      end
      m_head = m_head + $countones(m);
    end
  endtask

  logic [13:0] exp_ptr;

  initial begin
    n_checks = 0; n_errors = 0; m_head = 0; m_tail = 0;
    for (int i = 0; i < DEPTH; i++) m_dvalid[i] = 1'b0;
    rst_n = 1'b0;
    flush_i = 1'b0; alloc_req_i = 1'b0; alloc_valid_i = '0; alloc_payload_i = '0;
    alloc_excp_i = '0; alloc_is_br_i = '0; alloc_serial_i = '0;
    wb_valid_i = '0; wb_idx_i = '0; wb_head_only_i = '0; wb_excp_i = '0;
    wb_redirect_i = '0; wb_data_i = '0; cmt_ready_i = 1'b0;

    // Reset state
    #12;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_ptr", 64'(alloc_ptr_o), 64'({7'd1, 7'd0}));
    chk("rst_cmt", 64'(cmt_valid_o), 64'd0);
    chk("rst_wbrdy", 64'(wb_ready_o), 64'h1f);
    wb_head_only_i = 5'b11111;
    #1 chk("rst_wbrdy_ho", 64'(wb_ready_o), 64'h0);
    next_cycle();
    rst_n = 1'b1;

    // Fill to full, two per cycle, no write-back
    for (int k = 0; k < 32; k++) begin
      next_cycle();
      exp_ptr = {7'(m_tail + 1), 7'(m_tail)};
      alloc2(2'b00, 2'b00, 2'b00, 1'b1);
      #1;
      chk($sformatf("fill_count%0d", k), 64'(count_o), 64'(2 * k));
      chk($sformatf("fill_ready%0d", k), 64'(alloc_ready_o), 64'd1);
      chk($sformatf("fill_ptr%0d", k), 64'(alloc_ptr_o), 64'(exp_ptr));
    end
    next_cycle();
    alloc2(2'b00, 2'b00, 2'b00, 1'b0);
    #1;
    chk("full_count", 64'(count_o), 64'd64);
    chk("full_full", 64'(full_o), 64'd1);
    chk("full_ready", 64'(alloc_ready_o), 64'd0);
    chk("full_ptr", 64'(alloc_ptr_o), 64'({7'd65, 7'd64}));
    chk("full_cmt", 64'(cmt_valid_o), 64'd0);
    next_cycle();
    #1 chk("full_hold", 64'(count_o), 64'd64);
    flush_i = 1'b1;
    alloc2(2'b00, 2'b00, 2'b00, 1'b0);
    cmt_ready_i = 1'b1;
    exp_q.delete(); m_head = 0; m_tail = 0;
    next_cycle();
    #1;
    chk("fflush_count", 64'(count_o), 64'd0);
    chk("fflush_ptr", 64'(alloc_ptr_o), 64'({7'd1, 7'd0}));

    // Out-of-order write-back 3,2,1,0 then one group of four
    alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    next_cycle(); alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    for (int k = 3; k >= 0; k--) begin
      next_cycle();
      wb(0, k, 1'b0, 1'b0, 1'b1);
      cmt_ready_i = 1'b1;
      #1;
      chk($sformatf("ooo_wait%0d", k), 64'(cmt_valid_o), 64'd0);
      chk($sformatf("ooo_count%0d", k), 64'(count_o), 64'd4);
    end
    next_cycle();
    #1 check_group("ooo", 4'b1111, 1'b1);
    next_cycle();
    #1;
    chk("ooo_count_after", 64'(count_o), 64'd0);
    chk("ooo_empty_after", 64'(empty_o), 64'd1);

    // Redirect terminates the group; held group stays put
    alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    next_cycle(); alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    next_cycle();
    wb(0, 4, 1'b0, 1'b0, 1'b1); wb(1, 5, 1'b1, 1'b0, 1'b1);
    wb(2, 6, 1'b0, 1'b0, 1'b1); wb(3, 7, 1'b0, 1'b0, 1'b1);
    next_cycle();
    #1 check_group("redir_hold", 4'b0011, 1'b0);
    chk("redir_flag", 64'(cmt_redirect_o & 4'b0011), 64'b0010);
    next_cycle();
    #1 check_group("redir", 4'b0011, 1'b1);
    next_cycle();
    #1 check_group("redir_next", 4'b0011, 1'b1);
    chk("redir_next_flag", 64'(cmt_redirect_o & 4'b0011), 64'd0);
    next_cycle();
    #1 chk("redir_count", 64'(count_o), 64'd0);

    // Head-only write-back waits for its entry to reach head
    alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    next_cycle(); alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    next_cycle();
    wb(0, 8, 1'b0, 1'b0, 1'b1); wb(1, 9, 1'b0, 1'b0, 1'b1); wb(4, 10, 1'b0, 1'b1, 1'b0);
    #1 chk("ho_reject", 64'(wb_ready_o), 64'b01111);
    next_cycle();
    #1 check_group("ho_first", 4'b0011, 1'b1);
    next_cycle();
    wb(4, 10, 1'b0, 1'b1, 1'b1);
    #1;
    chk("ho_accept", 64'(wb_ready_o), 64'b11111);
    check_group("ho_notyet", 4'b0000, 1'b0);
    next_cycle();
    #1 check_group("ho_commit", 4'b0001, 1'b1);
    next_cycle();
    wb(0, 11, 1'b0, 1'b0, 1'b1);
    #1 check_group("ho_wait11", 4'b0000, 1'b0);
    next_cycle();
    #1 check_group("ho_last", 4'b0001, 1'b1);
    next_cycle();
    #1 chk("ho_empty", 64'(empty_o), 64'd1);

    // Flush against allocate and commit; late write-back dropped
    alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    next_cycle();
    wb(0, 12, 1'b0, 1'b0, 1'b1); wb(1, 13, 1'b0, 1'b0, 1'b1);
    next_cycle();
    #1 chk("fl_before", 64'(cmt_valid_o), 64'b0011);
    flush_i = 1'b1;
    alloc2(2'b00, 2'b00, 2'b00, 1'b0);
    cmt_ready_i = 1'b1;
    exp_q.delete(); m_head = 0; m_tail = 0;
    next_cycle();
    wb(0, 12, 1'b0, 1'b0, 1'b0); wb(2, 0, 1'b0, 1'b0, 1'b0);
    wb_head_only_i[3] = 1'b1;
    #1;
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_empty", 64'(empty_o), 64'd1);
    chk("fl_cmt", 64'(cmt_valid_o), 64'd0);
    chk("fl_ptr", 64'(alloc_ptr_o), 64'({7'd1, 7'd0}));
    chk("fl_wbrdy", 64'(wb_ready_o), 64'b10111);

    // Branch limit: branches at idx0 and idx2
    next_cycle(); alloc2(2'b01, 2'b00, 2'b00, 1'b1);
    next_cycle(); alloc2(2'b01, 2'b00, 2'b00, 1'b1);
    #1;
    chk("br_count2", 64'(count_o), 64'd2);
    chk("stray_dropped", 64'(cmt_valid_o), 64'd0);
    next_cycle();
    for (int p = 0; p < 4; p++) wb(p, p, 1'b0, 1'b0, 1'b1);
    #1 chk("br_count4", 64'(count_o), 64'd4);
    next_cycle();
`ifdef ROB_BR_LIMIT_EN
    #1 check_group("br", 4'b0011, 1'b1);
    next_cycle();
    #1 check_group("br_second", 4'b0011, 1'b1);
`else
    #1 check_group("br", 4'b1111, 1'b1);
`endif
    next_cycle();
    #1 chk("br_empty", 64'(count_o), 64'd0);

    // Front-end exception completes at allocate; serial closes the group
    alloc2(2'b00, 2'b01, 2'b00, 1'b1);
    next_cycle();
    #1;
    check_group("excp", 4'b0001, 1'b1);
    chk("excp_flag", 64'(cmt_excp_o[0]), 64'd1);
    alloc2(2'b00, 2'b00, 2'b01, 1'b1);
    next_cycle();
    wb(0, 5, 1'b0, 1'b0, 1'b1); wb(1, 6, 1'b0, 1'b0, 1'b1); wb(2, 7, 1'b0, 1'b0, 1'b1);
    #1 chk("simul_count", 64'(count_o), 64'd3);
    next_cycle();
    #1 check_group("serial", 4'b0011, 1'b1);
    next_cycle();
    #1 check_group("serial_next", 4'b0001, 1'b1);
    next_cycle();
    #1;
    chk("serial_empty", 64'(count_o), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-operation
    alloc2(2'b00, 2'b00, 2'b00, 1'b1);
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_empty", 64'(empty_o), 64'd1);
    chk("arst_ptr", 64'(alloc_ptr_o), 64'({7'd1, 7'd0}));
    exp_q.delete(); m_head = 0; m_tail = 0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    #1 chk("arst_after", 64'(count_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
